// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode constants and ALU operation codes.
package mips_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_IEXEC  = 4'd11,
      S_IWB    = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_RTYPE = 4'd2;
   localparam logic [3:0] ALU_AND   = 4'd3;
   localparam logic [3:0] ALU_OR    = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;

   // Opcodes the datapath implements; HALT is handled separately because its
   // value is a parameter of the controller.
   function automatic logic op_known(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  ||
             (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_SLTI) ||
             (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_LW)   ||
             (op == OP_SW);
   endfunction

   function automatic logic [3:0] imm_aluop(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational output decoder: current state (plus op and mem_rdy where a
// strobe depends on them) to datapath strobes and the illegal-opcode pulse.
module mc_ctrl_dec
   import mips_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'h3F
) (
   input  state_t     state_i,
   input  logic [5:0] op_i,
   input  logic       mem_rdy_i,
   output logic       pc_wr_o,
   output logic       pc_wr_cond_o,
   output logic       i_or_d_o,
   output logic       ir_wr_o,
   output logic       mem_rd_o,
   output logic       mem_wr_o,
   output logic       mem_to_reg_o,
   output logic       reg_dst_o,
   output logic       reg_wr_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] pc_src_o,
   output logic [3:0] alu_op_o,
   output logic       branch_op_o,
   output logic       ill_op_o
);

   always_comb begin
      pc_wr_o      = 1'b0;
      pc_wr_cond_o = 1'b0;
      i_or_d_o     = 1'b0;
      ir_wr_o      = 1'b0;
      mem_rd_o     = 1'b0;
      mem_wr_o     = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_dst_o    = 1'b0;
      reg_wr_o     = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      pc_src_o     = 2'b00;
      alu_op_o     = ALU_ADD;
      branch_op_o  = 1'b0;
      ill_op_o     = 1'b0;
      case (state_i)
         S_FETCH: begin
            mem_rd_o    = 1'b1;
            alu_src_b_o = 2'b01;
            ir_wr_o     = mem_rdy_i;
            pc_wr_o     = mem_rdy_i;
         end
         // The ALU adds PC+4 to the shifted immediate here so BRANCH has its target.
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            ill_op_o    = !op_known(op_i) && (op_i != HALT_OP);
         end
         S_MEMADR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
         end
         S_MEMRD: begin
            mem_rd_o = 1'b1;
            i_or_d_o = 1'b1;
         end
         S_MEMWR: begin
            i_or_d_o = 1'b1;
            mem_wr_o = mem_rdy_i;
         end
         S_MEMWB: begin
            reg_wr_o     = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_RTYPE;
         end
         S_RWB: begin
            reg_wr_o  = 1'b1;
            reg_dst_o = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = imm_aluop(op_i);
         end
         S_IWB: begin
            reg_wr_o = 1'b1;
            alu_op_o = imm_aluop(op_i);
         end
         S_BRANCH: begin
            pc_wr_cond_o = 1'b1;
            alu_src_a_o  = 1'b1;
            alu_op_o     = ALU_SUB;
            pc_src_o     = 2'b01;
            branch_op_o  = op_i[0];
         end
         S_JUMP: begin
            pc_wr_o  = 1'b1;
            pc_src_o = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: state register, next-state logic and the
// retired-instruction counter; strobes come from mc_ctrl_dec.
module mc_ctrl
   import mips_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'h3F,
   parameter int         CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op,
   input  logic             mem_rdy,
   output logic             PCWr,
   output logic             PCWrCond,
   output logic             IorD,
   output logic             IRWr,
   output logic             MemRd,
   output logic             MemWr,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWr,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic [3:0]       ALUOp,
   output logic             BranchOp,
   output logic             ill_op,
   output logic             halted,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [3:0]       state
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // retire marks the edge on which an instruction finishes and returns to FETCH.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            if ((op == OP_LW) || (op == OP_SW))        state_d = S_MEMADR;
            else if (op == OP_RTYPE)                   state_d = S_EXEC;
            else if ((op == OP_BEQ) || (op == OP_BNE)) state_d = S_BRANCH;
            else if (op == OP_J)                       state_d = S_JUMP;
            else if ((op == OP_ADDI) || (op == OP_ANDI) ||
                     (op == OP_ORI)  || (op == OP_SLTI)) state_d = S_IEXEC;
            else if (op == HALT_OP)                    state_d = S_HALT;
            else                                       state_d = S_FETCH;
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWR: begin
            if (mem_rdy) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:  state_d = S_RWB;
         S_IEXEC: state_d = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (retire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   mc_ctrl_dec #(
      .HALT_OP (HALT_OP)
   ) u_dec (
      .state_i      (state_q),
      .op_i         (op),
      .mem_rdy_i    (mem_rdy),
      .pc_wr_o      (PCWr),
      .pc_wr_cond_o (PCWrCond),
      .i_or_d_o     (IorD),
      .ir_wr_o      (IRWr),
      .mem_rd_o     (MemRd),
      .mem_wr_o     (MemWr),
      .mem_to_reg_o (MemtoReg),
      .reg_dst_o    (RegDst),
      .reg_wr_o     (RegWr),
      .alu_src_a_o  (ALUSrcA),
      .alu_src_b_o  (ALUSrcB),
      .pc_src_o     (PCSrc),
      .alu_op_o     (ALUOp),
      .branch_op_o  (BranchOp),
      .ill_op_o     (ill_op)
   );

   assign halted   = (state_q == S_HALT);
   assign inst_cnt = cnt_q;
   assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected state/strobe scoreboard
// driven from queues, plus scenario checks on counter, pulses and reset.
module tb_mc_ctrl;

   localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                          MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7,
                          RWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, IEXEC = 4'd11,
                          IWB = 4'd12, HALT = 4'd13;
   localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, BNE = 6'h05,
                          JMP = 6'h02, ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D,
                          SLTI = 6'h0A, HLT = 6'h3F, BAD = 6'h3B;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_rdy = 1'b0;
   logic [5:0]  op = 6'd0;
   logic        PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, MemtoReg, RegDst, RegWr;
   logic        ALUSrcA, BranchOp, ill_op, halted;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [3:0]  ALUOp, state;
   logic [31:0] inst_cnt;
   logic [20:0] obs;

   logic [3:0]  exp_q[$];
   logic        rdy_q[$];
   logic [5:0]  op_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   mc_ctrl #(.HALT_OP(6'h3F), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_rdy(mem_rdy),
      .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .IRWr(IRWr), .MemRd(MemRd),
      .MemWr(MemWr), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWr(RegWr),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .BranchOp(BranchOp), .ill_op(ill_op), .halted(halted), .inst_cnt(inst_cnt),
      .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, MemtoReg, RegDst, RegWr,
                 ALUSrcA, ALUSrcB, PCSrc, ALUOp, BranchOp, ill_op, halted};

   // Reference output table written from the control-signal description.
   function automatic logic [20:0] exp_out(input logic [3:0] s, input logic [5:0] o,
                                           input logic r);
      logic pcwr, pcwrc, iord, irwr, mrd, mwr, m2r, rdst, rwr, asa, bop, ill, hlt;
      logic [1:0] asb, pcs;
      logic [3:0] aop;
      {pcwr, pcwrc, iord, irwr, mrd, mwr, m2r, rdst, rwr, asa, bop, ill, hlt} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 4'd0;
      case (s)
         FETCH:  begin mrd = 1; asb = 2'b01; irwr = r; pcwr = r; end
         DECODE: begin
            asb = 2'b11;
            ill = !(o inside {LW, SW, RT, BEQ, BNE, JMP, ADDI, ANDI, ORI, SLTI, HLT});
         end
         MEMADR: begin asa = 1; asb = 2'b10; end
         MEMRD:  begin mrd = 1; iord = 1; end
         MEMWR:  begin iord = 1; mwr = r; end
         MEMWB:  begin rwr = 1; m2r = 1; end
         EXEC:   begin asa = 1; aop = 4'd2; end
         RWB:    begin rwr = 1; rdst = 1; end
         IEXEC, IWB: begin
            if (s == IEXEC) begin asa = 1; asb = 2'b10; end
            else rwr = 1;
            aop = (o == ANDI) ? 4'd3 : (o == ORI) ? 4'd4 : (o == SLTI) ? 4'd5 : 4'd0;
         end
         BRANCH: begin pcwrc = 1; asa = 1; aop = 4'd1; pcs = 2'b01; bop = o[0]; end
         JUMP:   begin pcwr = 1; pcs = 2'b10; end
         HALT:   hlt = 1;
         default: ;
      endcase
      return {pcwr, pcwrc, iord, irwr, mrd, mwr, m2r, rdst, rwr, asa, asb, pcs, aop,
              bop, ill, hlt};
   endfunction

   task automatic cyc(input logic r, input logic [5:0] o);
      @(negedge clk);
      mem_rdy = r;
      op = o;
      #1;
   endtask

   task automatic push(input logic [3:0] s, input logic r, input logic [5:0] o);
      exp_q.push_back(s);
      rdy_q.push_back(r);
      op_q.push_back(o);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if (state !== IDLE || inst_cnt !== 32'd0 || obs !== 21'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: state=%0d cnt=%0d outs=%h, want 0/0/0", state, inst_cnt, obs);
      end
      rst_n = 1'b1;
      mem_rdy = 1'b1;
      op = LW;
      #1;
      tests_run++;
      if (state !== IDLE || obs !== 21'd0) begin
         tests_failed++;
         $display("FAIL reset_release: state=%0d outs=%h, want IDLE and 0", state, obs);
      end
   endtask

   task automatic test_lw();
      logic [3:0] e; logic r; logic [5:0] o; int rw_cycles;
      rw_cycles = 0;
      push(FETCH, 1, LW); push(DECODE, 1, LW); push(MEMADR, 1, LW);
      push(MEMRD, 1, LW); push(MEMWB, 1, LW); push(FETCH, 1, LW);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         if (RegWr) rw_cycles++;
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL lw_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
      end
      tests_run++;
      if (rw_cycles !== 1 || inst_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL lw_result: regwr_cycles=%0d cnt=%0d, want 1/1", rw_cycles, inst_cnt);
      end
   endtask

   task automatic test_sw_stall();
      logic [3:0] e; logic r; logic [5:0] o; int mw;
      mw = 0;
      push(DECODE, 1, SW); push(MEMADR, 1, SW);
      push(MEMWR, 0, SW); push(MEMWR, 0, SW); push(MEMWR, 0, SW);
      push(MEMWR, 1, SW); push(FETCH, 1, SW);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         if (MemWr) mw++;
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL sw_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
      end
      tests_run++;
      if (mw !== 1 || inst_cnt !== 32'd2) begin
         tests_failed++;
         $display("FAIL sw_result: memwr_pulses=%0d cnt=%0d, want 1/2", mw, inst_cnt);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] e; logic r; logic [5:0] o; int ill_cycles;
      ill_cycles = 0;
      push(DECODE, 1, BAD); push(FETCH, 1, BAD);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         if (ill_op) ill_cycles++;
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL ill_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
      end
      tests_run++;
      if (ill_cycles !== 1 || inst_cnt !== 32'd2) begin
         tests_failed++;
         $display("FAIL ill_result: ill_cycles=%0d cnt=%0d, want 1/2", ill_cycles, inst_cnt);
      end
   endtask

   task automatic test_branch_jump();
      logic [3:0] e; logic r; logic [5:0] o;
      push(DECODE, 1, BEQ); push(BRANCH, 1, BEQ); push(FETCH, 1, BEQ);
      push(DECODE, 1, JMP); push(JUMP, 1, JMP); push(FETCH, 1, JMP);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL br_j_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
         if (e == BRANCH) begin
            tests_run++;
            if (PCWrCond !== 1'b1 || PCSrc !== 2'b01 || BranchOp !== 1'b0) begin
               tests_failed++;
               $display("FAIL beq_strobes: pcwrcond=%b pcsrc=%b bop=%b, want 1/01/0", PCWrCond, PCSrc, BranchOp);
            end
         end
      end
      tests_run++;
      if (inst_cnt !== 32'd4) begin
         tests_failed++;
         $display("FAIL br_j_cnt: cnt=%0d, want 4", inst_cnt);
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0] e; logic r; logic [5:0] o; logic [5:0] imm_ops[4];
      imm_ops = '{ADDI, ANDI, ORI, SLTI};
      push(DECODE, 1, RT); push(EXEC, 1, RT); push(RWB, 1, RT); push(FETCH, 1, RT);
      for (int i = 0; i < 4; i++) begin
         push(DECODE, 1, imm_ops[i]); push(IEXEC, 1, imm_ops[i]);
         push(IWB, 1, imm_ops[i]); push(FETCH, 1, imm_ops[i]);
      end
      push(DECODE, 1, BNE); push(BRANCH, 1, BNE);
      push(FETCH, 0, BNE); push(FETCH, 0, BNE); push(FETCH, 1, BNE);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL alu_step op=%h: state=%0d outs=%h, want state=%0d outs=%h", o, state, obs, e, exp_out(e, o, r));
         end
      end
      tests_run++;
      if (inst_cnt !== 32'd10) begin
         tests_failed++;
         $display("FAIL alu_cnt: cnt=%0d, want 10", inst_cnt);
      end
   endtask

   task automatic test_reset_mid_memrd();
      logic [3:0] e; logic r; logic [5:0] o;
      push(DECODE, 1, LW); push(MEMADR, 1, LW); push(MEMRD, 0, LW);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL rst_mid_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (state !== IDLE || obs !== 21'd0 || inst_cnt !== 32'd0) begin
         tests_failed++;
         $display("FAIL rst_async: state=%0d outs=%h cnt=%0d, want 0/0/0", state, obs, inst_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_rdy = 1'b1;
      #1;
      tests_run++;
      if (state !== IDLE || inst_cnt !== 32'd0) begin
         tests_failed++;
         $display("FAIL rst_after: state=%0d cnt=%0d, want IDLE/0", state, inst_cnt);
      end
   endtask

   task automatic test_halt();
      logic [3:0] e; logic r; logic [5:0] o;
      push(FETCH, 1, HLT); push(DECODE, 1, HLT);
      for (int i = 0; i < 100; i++) push(HALT, i[0], HLT);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); r = rdy_q.pop_front(); o = op_q.pop_front();
         cyc(r, o);
         tests_run++;
         if (state !== e || obs !== exp_out(e, o, r)) begin
            tests_failed++;
            $display("FAIL halt_step: state=%0d outs=%h, want state=%0d outs=%h", state, obs, e, exp_out(e, o, r));
         end
      end
      tests_run++;
      if (halted !== 1'b1 || inst_cnt !== 32'd0) begin
         tests_failed++;
         $display("FAIL halt_result: halted=%b cnt=%0d, want 1/0", halted, inst_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_illegal();
      test_branch_jump();
      test_alu_ops();
      test_reset_mid_memrd();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
